fp_align_pipe: RTL and testbench
================================

# fp_align_pipe

Parametrised, two-stage pipelined operand-alignment stage for the pipelined FPU adder path. Accepts two unpacked floating-point operands per cycle under a valid/ready handshake. Orders them by magnitude and right-shifts the smaller mantissa by the exponent difference, keeping guard, round and sticky bits. Emits both mantissas on a common exponent for the downstream add/normalise stages.

## Interface
Parameters:
- EXP_W, 8, exponent width (biased, unsigned)
- MAN_W, 24, mantissa width including the explicit hidden bit
- TAG_W, 4, sideband tag width, passed through unchanged

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  reset, synchronous, active-high
- valid_i  in  1  input operand pair valid
- ready_o  out  1  stage can accept an operand pair this cycle
- a_sign_i / b_sign_i  in  1  operand signs
- a_exp_i / b_exp_i  in  EXP_W  operand exponents
- a_mant_i / b_mant_i  in  MAN_W  operand mantissas
- tag_i  in  TAG_W  sideband tag
- valid_o  out  1  output valid
- ready_i  in  1  downstream accepts output
- exp_o  out  EXP_W  common (larger) exponent
- sign_l_o / sign_s_o  out  1  signs of the larger and smaller operands
- mant_l_o  out  MAN_W+3  larger mantissa, {mant, 3'b000}
- mant_s_o  out  MAN_W+3  aligned smaller mantissa, {mant bits, G, R, S}
- swap_o  out  1  1 when b is the larger operand
- eff_sub_o  out  1  a_sign_i XOR b_sign_i
- tag_o  out  TAG_W  tag of this result

## Operation
- Stage 1 (compare/order):
  - Larger operand is decided by comparing exponents. On equal exponents, compare mantissas; on full tie, a is larger (swap=0).
  - Register: d = exp_l − exp_s (EXP_W bits, unsigned, never negative), ordered operands, exp_l, swap, eff_sub, tag.
- Stage 2 (shift/sticky):
  - mant_l_o = {mant_l, 3'b000}.
  - Form X = {mant_s, 3'b000} (MAN_W+3 bits). mant_s_o = X >> d, with bit 0 ORed with the OR of every bit shifted out.
  - If d ≥ MAN_W+3: mant_s_o = {(MAN_W+2)'b0, |mant_s}.
  - exp_o = exp_l.
- No special handling of zero/Inf/NaN (handled upstream). Zero mantissas propagate as zero with sticky 0.
- Handshake:
  - Per-stage valid bits s1_v and s2_v.
  - en2 = !s2_v || ready_i; en1 = !s1_v || en2; ready_o = en1.
  - Input transfer when valid_i && ready_o.
  - valid_o = s2_v.
  - A stage loads when its enable is high. The stage valid becomes the upstream valid (valid_i for s1, s1_v for s2). Data registers load only when the loaded valid is 1.
- Output data and valid_o are stable while valid_o && !ready_i.

## Timing
- Latency: 2 cycles from input transfer to valid_o.
- Throughput: 1 pair/cycle when ready_i is held high.
- ready_o is combinational from ready_i and internal valids; no combinational path from valid_i to ready_o.
- Reset (rst_i high at an edge): s1_v=0, s2_v=0, all data registers 0.
  - Outputs after reset: valid_o=0, exp_o=0, mantissas 0, swap_o=0, eff_sub_o=0, tag_o=0, ready_o=1.
- Reset mid-operation discards in-flight pairs; no output appears for them.
- Full pipeline with ready_i=0: ready_o=0, both stages hold.
- When ready_i rises, output and input transfers happen in the same cycle; no bubble.
- Accept and drain in the same cycle, including with both stages full, is legal and loses nothing.

## Test plan
All scenarios use default parameters.
1. a={0,130,0xC00000}, b={0,128,0x800000}, ready_i=1.
   - 2 cycles later: exp_o=130, mant_l_o=0x6000000, mant_s_o=0x1000000, swap_o=0, eff_sub_o=0.
2. a={1,126,0x800001}, b={0,130,0x900000}.
   - d=4, swap_o=1, eff_sub_o=1, exp_o=130, mant_s_o=0x0400001 (sticky set).
3. Exponent tie with a={0,127,0x800000}, b={0,127,0xA00000}: swap_o=1, mant_s_o=0x4000000.
   - Full tie: swap_o=0.
4. Large shift: d=40, mant_s=0x800000 → mant_s_o=0x0000001. With mant_s=0 → 0.
5. Back-pressure:
   - Stream 6 tagged pairs (tags 0–5) with ready_i toggling randomly.
   - Required: tags emerge in order with no loss or duplication, and outputs are stable while stalled.
   - With ready_i=0 for 3+ cycles, ready_o=0 after 2 accepts.
6. Assert rst_i with 2 pairs in flight.
   - Next cycle: valid_o=0, ready_o=1, all data outputs 0, and the dropped pairs never appear.

Source files
------------

// File: rtl/fp_align_pipe_if.sv
// Operand/result bus for the FPU alignment stage: input pair handshake on one side,
// aligned result handshake on the other.
interface fp_align_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 24,
  parameter int TAG_W = 4
) ();
  logic               valid_i;
  logic               ready_o;
  logic               a_sign_i;
  logic               b_sign_i;
  logic [EXP_W-1:0]   a_exp_i;
  logic [EXP_W-1:0]   b_exp_i;
  logic [MAN_W-1:0]   a_mant_i;
  logic [MAN_W-1:0]   b_mant_i;
  logic [TAG_W-1:0]   tag_i;
  logic               valid_o;
  logic               ready_i;
  logic [EXP_W-1:0]   exp_o;
  logic               sign_l_o;
  logic               sign_s_o;
  logic [MAN_W+2:0]   mant_l_o;
  logic [MAN_W+2:0]   mant_s_o;
  logic               swap_o;
  logic               eff_sub_o;
  logic [TAG_W-1:0]   tag_o;

  modport slave (
    input  valid_i, a_sign_i, b_sign_i, a_exp_i, b_exp_i, a_mant_i, b_mant_i, tag_i, ready_i,
    output ready_o, valid_o, exp_o, sign_l_o, sign_s_o, mant_l_o, mant_s_o, swap_o,
           eff_sub_o, tag_o
  );

  modport master (
    output valid_i, a_sign_i, b_sign_i, a_exp_i, b_exp_i, a_mant_i, b_mant_i, tag_i, ready_i,
    input  ready_o, valid_o, exp_o, sign_l_o, sign_s_o, mant_l_o, mant_s_o, swap_o,
           eff_sub_o, tag_o
  );
endinterface

// File: rtl/fp_align_pipe.sv
// Two-stage FPU adder alignment: stage 1 orders operands by magnitude, stage 2 shifts
// the smaller mantissa onto the larger exponent keeping guard/round/sticky.
module fp_align_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 24,
  parameter int TAG_W = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  fp_align_pipe_if.slave  io_bus
);
  localparam int SH_W = MAN_W + 3;

  // Right shift with every shifted-out bit folded into the sticky LSB.
  function automatic logic [SH_W-1:0] align_shift(input logic [MAN_W-1:0] mant,
                                                  input logic [EXP_W-1:0] d);
    logic [SH_W-1:0] x;
    logic [SH_W-1:0] mask;
    logic [SH_W-1:0] res;
    x    = {mant, 3'b000};
    mask = '0;
    res  = '0;
    if (int'(d) >= SH_W) begin
      res = {{(SH_W-1){1'b0}}, |mant};
    end else begin
      mask   = ~({SH_W{1'b1}} << d);
      res    = x >> d;
      res[0] = res[0] | (|(x & mask));
    end
    return res;
  endfunction

  logic               w_en1, w_en2, w_a_larger;
  logic [EXP_W-1:0]   w_exp_l, w_exp_s, w_d;
  logic [MAN_W-1:0]   w_mant_l, w_mant_s;
  logic               w_sign_l, w_sign_s;
  logic [SH_W-1:0]    w_mant_s_al;

  logic               r_s1_v, r_s1_sign_l, r_s1_sign_s, r_s1_swap, r_s1_eff_sub;
  logic [EXP_W-1:0]   r_s1_exp_l, r_s1_d;
  logic [MAN_W-1:0]   r_s1_mant_l, r_s1_mant_s;
  logic [TAG_W-1:0]   r_s1_tag;

  logic               r_s2_v, r_sign_l, r_sign_s, r_swap, r_eff_sub;
  logic [EXP_W-1:0]   r_exp;
  logic [SH_W-1:0]    r_mant_l, r_mant_s;
  logic [TAG_W-1:0]   r_tag;

  assign w_en2          = !r_s2_v || io_bus.ready_i;
  assign w_en1          = !r_s1_v || w_en2;
  assign io_bus.ready_o = w_en1;

  // Magnitude compare: exponent first, then mantissa; a full tie keeps a as larger.
  always_comb begin
    w_a_larger = (io_bus.a_exp_i > io_bus.b_exp_i) ||
                 ((io_bus.a_exp_i == io_bus.b_exp_i) && (io_bus.a_mant_i >= io_bus.b_mant_i));
    w_exp_l  = '0;
    w_exp_s  = '0;
    w_mant_l = '0;
    w_mant_s = '0;
    w_sign_l = 1'b0;
    w_sign_s = 1'b0;
    if (w_a_larger) begin
      w_exp_l  = io_bus.a_exp_i;
      w_exp_s  = io_bus.b_exp_i;
      w_mant_l = io_bus.a_mant_i;
      w_mant_s = io_bus.b_mant_i;
      w_sign_l = io_bus.a_sign_i;
      w_sign_s = io_bus.b_sign_i;
    end else begin
      w_exp_l  = io_bus.b_exp_i;
      w_exp_s  = io_bus.a_exp_i;
      w_mant_l = io_bus.b_mant_i;
      w_mant_s = io_bus.a_mant_i;
      w_sign_l = io_bus.b_sign_i;
      w_sign_s = io_bus.a_sign_i;
    end
    w_d = w_exp_l - w_exp_s;
  end

  assign w_mant_s_al = align_shift(r_s1_mant_s, r_s1_d);

  // Stage 1 register: ordered operands and exponent difference.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_s1_v       <= 1'b0;
      r_s1_exp_l   <= '0;
      r_s1_d       <= '0;
      r_s1_mant_l  <= '0;
      r_s1_mant_s  <= '0;
      r_s1_sign_l  <= 1'b0;
      r_s1_sign_s  <= 1'b0;
      r_s1_swap    <= 1'b0;
      r_s1_eff_sub <= 1'b0;
      r_s1_tag     <= '0;
    end else if (w_en1) begin
      r_s1_v <= io_bus.valid_i;
      if (io_bus.valid_i) begin
        r_s1_exp_l   <= w_exp_l;
        r_s1_d       <= w_d;
        r_s1_mant_l  <= w_mant_l;
        r_s1_mant_s  <= w_mant_s;
        r_s1_sign_l  <= w_sign_l;
        r_s1_sign_s  <= w_sign_s;
        r_s1_swap    <= !w_a_larger;
        r_s1_eff_sub <= io_bus.a_sign_i ^ io_bus.b_sign_i;
        r_s1_tag     <= io_bus.tag_i;
      end
    end
  end

  // Stage 2 register: aligned mantissas on the common exponent; holds while stalled.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_s2_v    <= 1'b0;
      r_exp     <= '0;
      r_mant_l  <= '0;
      r_mant_s  <= '0;
      r_sign_l  <= 1'b0;
      r_sign_s  <= 1'b0;
      r_swap    <= 1'b0;
      r_eff_sub <= 1'b0;
      r_tag     <= '0;
    end else if (w_en2) begin
      r_s2_v <= r_s1_v;
      if (r_s1_v) begin
        r_exp     <= r_s1_exp_l;
        r_mant_l  <= {r_s1_mant_l, 3'b000};
        r_mant_s  <= w_mant_s_al;
        r_sign_l  <= r_s1_sign_l;
        r_sign_s  <= r_s1_sign_s;
        r_swap    <= r_s1_swap;
        r_eff_sub <= r_s1_eff_sub;
        r_tag     <= r_s1_tag;
      end
    end
  end

  assign io_bus.valid_o   = r_s2_v;
  assign io_bus.exp_o     = r_exp;
  assign io_bus.mant_l_o  = r_mant_l;
  assign io_bus.mant_s_o  = r_mant_s;
  assign io_bus.sign_l_o  = r_sign_l;
  assign io_bus.sign_s_o  = r_sign_s;
  assign io_bus.swap_o    = r_swap;
  assign io_bus.eff_sub_o = r_eff_sub;
  assign io_bus.tag_o     = r_tag;
endmodule

// File: tb/tb_fp_align_pipe.sv
// Directed bench for fp_align_pipe: alignment vectors, back-pressure ordering, stall and reset.
module tb_fp_align_pipe;
  logic clk = 1'b0;
  logic rst_i;
  int   n_pass  = 0;
  int   n_total = 0;

  fp_align_pipe_if bus ();

  fp_align_pipe dut (
    .clk_i  (clk),
    .rst_i  (rst_i),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
  endtask

  task automatic set_ops(input logic sa, input logic [7:0] ea, input logic [23:0] ma,
                         input logic sb, input logic [7:0] eb, input logic [23:0] mb,
                         input logic [3:0] tg);
    bus.a_sign_i = sa;  bus.a_exp_i = ea;  bus.a_mant_i = ma;
    bus.b_sign_i = sb;  bus.b_exp_i = eb;  bus.b_mant_i = mb;
    bus.tag_i    = tg;
  endtask

  task automatic run_case(input string nm,
                          input logic sa, input logic [7:0] ea, input logic [23:0] ma,
                          input logic sb, input logic [7:0] eb, input logic [23:0] mb,
                          input logic [3:0] tg, input logic [7:0] x_exp,
                          input logic [26:0] x_ml, input logic [26:0] x_ms,
                          input logic x_swap, input logic x_eff,
                          input logic x_sl, input logic x_ss);
    bus.ready_i = 1'b1;
    set_ops(sa, ea, ma, sb, eb, mb, tg);
    bus.valid_i = 1'b1;
    tick();
    bus.valid_i = 1'b0;
    chk({nm, ".lat1"}, bus.valid_o, 1'b0);
    tick();
    chk({nm, ".valid"},  bus.valid_o, 1'b1);
    chk({nm, ".exp"},    bus.exp_o, x_exp);
    chk({nm, ".mant_l"}, bus.mant_l_o, x_ml);
    chk({nm, ".mant_s"}, bus.mant_s_o, x_ms);
    chk({nm, ".swap"},   bus.swap_o, x_swap);
    chk({nm, ".eff"},    bus.eff_sub_o, x_eff);
    chk({nm, ".sign_l"}, bus.sign_l_o, x_sl);
    chk({nm, ".sign_s"}, bus.sign_s_o, x_ss);
    chk({nm, ".tag"},    bus.tag_o, tg);
    tick();
  endtask

  logic [26:0] bp_ms [6] = '{27'h4000000, 27'h3000000, 27'h1800000,
                             27'h0C00000, 27'h0600000, 27'h0300000};
  logic        bp_sw [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    int   sent, recv, cyc;
    logic in_x, out_x, stalled;

    rst_i       = 1'b1;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    set_ops(1'b0, 8'd0, 24'h0, 1'b0, 8'd0, 24'h0, 4'd0);
    tick();
    tick();
    rst_i = 1'b0;
    chk("rst.valid_o", bus.valid_o, 1'b0);
    chk("rst.ready_o", bus.ready_o, 1'b1);
    chk("rst.exp",     bus.exp_o, 8'd0);
    chk("rst.mant_l",  bus.mant_l_o, 27'h0);
    chk("rst.mant_s",  bus.mant_s_o, 27'h0);
    chk("rst.swap",    bus.swap_o, 1'b0);
    chk("rst.eff",     bus.eff_sub_o, 1'b0);
    chk("rst.tag",     bus.tag_o, 4'd0);

    // Directed alignment vectors
    run_case("t1",   1'b0, 8'd130, 24'hC00000, 1'b0, 8'd128, 24'h800000, 4'd1,
             8'd130, 27'h6000000, 27'h1000000, 1'b0, 1'b0, 1'b0, 1'b0);
    run_case("t2",   1'b1, 8'd126, 24'h800001, 1'b0, 8'd130, 24'h900000, 4'd2,
             8'd130, 27'h4800000, 27'h0400001, 1'b1, 1'b1, 1'b0, 1'b1);
    run_case("t3",   1'b0, 8'd127, 24'h800000, 1'b0, 8'd127, 24'hA00000, 4'd3,
             8'd127, 27'h5000000, 27'h4000000, 1'b1, 1'b0, 1'b0, 1'b0);
    run_case("t3tie",1'b1, 8'd127, 24'hA00000, 1'b1, 8'd127, 24'hA00000, 4'd4,
             8'd127, 27'h5000000, 27'h5000000, 1'b0, 1'b0, 1'b1, 1'b1);
    run_case("t4",   1'b0, 8'd170, 24'h800000, 1'b0, 8'd130, 24'h800000, 4'd5,
             8'd170, 27'h4000000, 27'h0000001, 1'b0, 1'b0, 1'b0, 1'b0);
    run_case("t4z",  1'b0, 8'd170, 24'h800000, 1'b1, 8'd130, 24'h000000, 4'd6,
             8'd170, 27'h4000000, 27'h0000000, 1'b0, 1'b1, 1'b0, 1'b1);
    run_case("d27",  1'b0, 8'd157, 24'h800000, 1'b0, 8'd130, 24'h800001, 4'd7,
             8'd157, 27'h4000000, 27'h0000001, 1'b0, 1'b0, 1'b0, 1'b0);
    run_case("d25",  1'b0, 8'd155, 24'h800000, 1'b0, 8'd130, 24'hC00000, 4'd8,
             8'd155, 27'h4000000, 27'h0000003, 1'b0, 1'b0, 1'b0, 1'b0);
    run_case("d1",   1'b0, 8'd131, 24'h800000, 1'b0, 8'd130, 24'h800001, 4'd9,
             8'd131, 27'h4000000, 27'h2000004, 1'b0, 1'b0, 1'b0, 1'b0);

    // Back-pressure stream: tag k has d = k (tag 0 is an exponent tie with b larger)
    sent = 0; recv = 0; cyc = 0; stalled = 1'b0;
    while (recv < 6 && cyc < 200) begin
      bus.ready_i = 1'($urandom_range(0, 1));
      if (sent < 6) begin
        set_ops(1'b0, 8'(100 + sent), 24'h800000, 1'b0, 8'd100, 24'hC00000, 4'(sent));
        bus.valid_i = 1'b1;
      end else begin
        bus.valid_i = 1'b0;
      end
      #1;
      if (stalled) chk("bp.hold_valid", bus.valid_o, 1'b1);
      if (bus.valid_o) begin
        chk("bp.tag",    bus.tag_o, 4'(recv));
        chk("bp.mant_s", bus.mant_s_o, bp_ms[recv]);
        chk("bp.swap",   bus.swap_o, bp_sw[recv]);
      end
      in_x    = bus.valid_i && bus.ready_o;
      out_x   = bus.valid_o && bus.ready_i;
      stalled = bus.valid_o && !bus.ready_i;
      tick();
      if (in_x)  sent++;
      if (out_x) recv++;
      cyc++;
    end
    chk("bp.received", 32'(recv), 32'd6);
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    tick();
    tick();
    chk("bp.no_extra", bus.valid_o, 1'b0);

    // Full stall: two accepts then ready_o drops; release gives same-cycle transfer
    bus.ready_i = 1'b0;
    set_ops(1'b0, 8'd130, 24'h800000, 1'b0, 8'd129, 24'h800000, 4'd6);
    bus.valid_i = 1'b1;
    #1;
    chk("st.rdy0", bus.ready_o, 1'b1);
    tick();
    set_ops(1'b0, 8'd130, 24'h800000, 1'b0, 8'd129, 24'h800000, 4'd7);
    #1;
    chk("st.rdy1", bus.ready_o, 1'b1);
    tick();
    set_ops(1'b0, 8'd130, 24'h800000, 1'b0, 8'd129, 24'h800000, 4'd8);
    #1;
    chk("st.rdy2", bus.ready_o, 1'b0);
    chk("st.valid", bus.valid_o, 1'b1);
    chk("st.tag_a", bus.tag_o, 4'd6);
    tick();
    chk("st.rdy3", bus.ready_o, 1'b0);
    chk("st.tag_b", bus.tag_o, 4'd6);
    tick();
    chk("st.rdy4", bus.ready_o, 1'b0);
    chk("st.ms_hold", bus.mant_s_o, 27'h2000000);
    bus.ready_i = 1'b1;
    #1;
    chk("st.rdy_rel", bus.ready_o, 1'b1);
    tick();
    bus.valid_i = 1'b0;
    chk("st.tag7", bus.tag_o, 4'd7);
    tick();
    chk("st.tag8", bus.tag_o, 4'd8);
    chk("st.v8", bus.valid_o, 1'b1);
    tick();
    chk("st.empty", bus.valid_o, 1'b0);

    // Reset with two pairs in flight
    bus.ready_i = 1'b0;
    set_ops(1'b1, 8'd140, 24'h900000, 1'b0, 8'd150, 24'hA00000, 4'hA);
    bus.valid_i = 1'b1;
    tick();
    bus.tag_i = 4'hB;
    tick();
    bus.valid_i = 1'b0;
    chk("rs.full", bus.valid_o, 1'b1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("rs.valid_o", bus.valid_o, 1'b0);
    chk("rs.ready_o", bus.ready_o, 1'b1);
    chk("rs.exp",     bus.exp_o, 8'd0);
    chk("rs.mant_l",  bus.mant_l_o, 27'h0);
    chk("rs.mant_s",  bus.mant_s_o, 27'h0);
    chk("rs.swap",    bus.swap_o, 1'b0);
    chk("rs.eff",     bus.eff_sub_o, 1'b0);
    chk("rs.sign_l",  bus.sign_l_o, 1'b0);
    chk("rs.tag",     bus.tag_o, 4'd0);
    bus.ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rs.dropped", bus.valid_o, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
